// File: rtl/reg_writeback_queue.sv
// Register-file writeback queue: buffers ALU and load results in an in-order
// FIFO and drains at most one entry per cycle onto the register-file write
// port. Also exports a mask of registers with a write still in flight.
module reg_writeback_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_dst,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_dst,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     wb_stall,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    output logic [(2**ADDR_W)-1:0]   busy_mask,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] dst_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [DEPTH-1:0]  ent_valid;

    logic              not_full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_dst;
    logic [DATA_W-1:0] push_data;

    // Ready depends only on registered occupancy and mem_valid, so a full
    // queue refuses input even when the head is leaving this cycle.
    assign not_full  = (count < FULL_CNT);
    assign mem_ready = not_full;
    assign alu_ready = not_full && !mem_valid;

    assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign pop       = (count != '0) && !wb_stall;
    assign push_dst  = mem_valid ? mem_dst  : alu_dst;
    assign push_data = mem_valid ? mem_data : alu_data;

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            dst_mem[tail]  <= push_dst;
            data_mem[tail] <= push_data;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head      <= head + PTR_W'(1);
                WriteReg  <= dst_mem[head];
                WriteData <= data_mem[head];
            end
            RegWrite <= pop;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(i) - head} < count) begin
                ent_valid[i] = 1'b1;
            end
        end
    end

    // Pending destinations: every live entry plus the write on the port.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy_mask[dst_mem[i]] = 1'b1;
            end
        end
        if (RegWrite) begin
            busy_mask[WriteReg] = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: reset flush, latency, priority,
// full/stall back-pressure, duplicate destinations and pointer wrap.
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_dst;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_dst;
    logic [15:0] mem_data;
    logic        wb_stall;
    logic        RegWrite;
    logic [3:0]  WriteReg;
    logic [15:0] WriteData;
    logic [15:0] busy_mask;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    reg_writeback_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_dst   (mem_dst),
        .mem_data  (mem_data),
        .wb_stall  (wb_stall),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .busy_mask (busy_mask),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [3:0] reg_idx, input logic [15:0] val);
        check_eq({tag, "_we"},   32'(RegWrite),  32'd1);
        check_eq({tag, "_reg"},  32'(WriteReg),  32'(reg_idx));
        check_eq({tag, "_data"}, 32'(WriteData), 32'(val));
    endtask

    initial begin
        int  saw_r5;
        logic acc;

        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_dst   = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_dst   = '0;
        mem_data  = '0;
        wb_stall  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_we",    32'(RegWrite), 32'd0);
        check_eq("rst_busy",  32'(busy_mask), 32'd0);
        check_eq("rst_wreg",  32'(WriteReg), 32'd0);
        check_eq("rst_mrdy",  32'(mem_ready), 32'd1);

        // Reset flush mid-drain
        alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 16'h1234;
        tick();
        alu_dst = 4'd5; alu_data = 16'h00FF;
        tick();
        alu_valid = 1'b0;
        check_write("flush_first", 4'd3, 16'h1234);
        check_eq("flush_cnt_pre", 32'(count), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_we",    32'(RegWrite), 32'd0);
        check_eq("flush_busy",  32'(busy_mask), 32'd0);
        saw_r5 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (RegWrite) saw_r5++;
        end
        check_eq("flush_no_r5", 32'(saw_r5), 32'd0);

        // Single-write latency
        alu_valid = 1'b1; alu_dst = 4'd7; alu_data = 16'hBEEF;
        #1;
        check_eq("lat_busy_pre", 32'(busy_mask), 32'd0);
        tick();
        alu_valid = 1'b0;
        check_eq("lat_n_we",    32'(RegWrite), 32'd0);
        check_eq("lat_n_count", 32'(count), 32'd1);
        check_eq("lat_n_busy",  32'(busy_mask), 32'h0080);
        tick();
        check_write("lat_n1", 4'd7, 16'hBEEF);
        check_eq("lat_n1_busy",  32'(busy_mask), 32'h0080);
        check_eq("lat_n1_count", 32'(count), 32'd0);
        tick();
        check_eq("lat_n2_we",   32'(RegWrite), 32'd0);
        check_eq("lat_n2_busy", 32'(busy_mask), 32'd0);

        // Memory priority over ALU
        alu_valid = 1'b1; alu_dst = 4'd1; alu_data = 16'h0001;
        mem_valid = 1'b1; mem_dst = 4'd2; mem_data = 16'h0002;
        #1;
        check_eq("pri_mrdy", 32'(mem_ready), 32'd1);
        check_eq("pri_ardy", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 1'b0;
        #1;
        check_eq("pri_ardy2", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check_write("pri_w1", 4'd2, 16'h0002);
        tick();
        check_write("pri_w2", 4'd1, 16'h0001);
        tick();
        check_eq("pri_idle", 32'(RegWrite), 32'd0);

        // Full queue under stall, fifth value held
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_dst   = 4'(4 + i);
            alu_data  = 16'(16'h000A + i);
            tick();
        end
        alu_dst = 4'd8; alu_data = 16'h000E;
        #1;
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_ardy",  32'(alu_ready), 32'd0);
        check_eq("full_mrdy",  32'(mem_ready), 32'd0);
        check_eq("full_we",    32'(RegWrite), 32'd0);
        check_eq("full_busy",  32'(busy_mask), 32'h00F0);
        tick();
        check_eq("stall_count", 32'(count), 32'd4);
        check_eq("stall_we",    32'(RegWrite), 32'd0);
        wb_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            acc = alu_valid && alu_ready;
            tick();
            if (acc) alu_valid = 1'b0;
            check_write($sformatf("drain%0d", i), 4'(4 + i), 16'(16'h000A + i));
        end
        check_eq("drain_vld_dropped", 32'(alu_valid), 32'd0);
        tick();
        check_eq("drain_end_we",    32'(RegWrite), 32'd0);
        check_eq("drain_end_count", 32'(count), 32'd0);

        // Duplicate destination
        alu_valid = 1'b1; alu_dst = 4'd9; alu_data = 16'h1111;
        tick();
        alu_data = 16'h2222;
        tick();
        alu_valid = 1'b0;
        check_write("dup_w1", 4'd9, 16'h1111);
        check_eq("dup_busy1", 32'(busy_mask[9]), 32'd1);
        tick();
        check_write("dup_w2", 4'd9, 16'h2222);
        check_eq("dup_busy2", 32'(busy_mask[9]), 32'd1);
        tick();
        check_eq("dup_we_off", 32'(RegWrite), 32'd0);
        check_eq("dup_busy3",  32'(busy_mask), 32'd0);

        // Streaming across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1'b1;
            alu_dst   = 4'(i);
            alu_data  = 16'(16'h0100 + i);
            tick();
            check_eq($sformatf("strm_count%0d", i), 32'(count), 32'd1);
            if (i > 0) begin
                check_write($sformatf("strm%0d", i - 1), 4'(i - 1), 16'(16'h0100 + i - 1));
            end
        end
        alu_valid = 1'b0;
        tick();
        check_write("strm9", 4'd9, 16'h0109);
        check_eq("strm_end_count", 32'(count), 32'd0);
        tick();
        check_eq("strm_end_we", 32'(RegWrite), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
